uart_tx_write_buffer: RTL and testbench

Parametrised transmit-side write buffer between the host write port and the UART transmitter. It accepts host writes into a DEPTH-entry FIFO instead of a single holding register. It launches one `start` pulse per queued word, but only when the transmitter is idle. It reports level, full/empty and a sticky overflow flag to the host.

---
 rtl/uart_pkg.sv | 17 +
 rtl/sync_fifo.sv | 82 ++++++++
 rtl/uart_tx_write_buffer.sv | 109 ++++++++++
 tb/tb_uart_tx_write_buffer.sv | 392 +++++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/uart_pkg.sv
// Shared types and default sizing for the UART transmit write buffer.
package uart_pkg;

    localparam int DEFAULT_DATA_W = 8;
    localparam int DEFAULT_DEPTH  = 16;

    // Launch FSM: IDLE waits for a queued word, START carries the one-cycle
    // pulse, WAIT_ACK waits for the transmitter to go busy, WAIT_DONE waits
    // for the frame to finish.
    typedef enum logic [1:0] {
        IDLE      = 2'd0,
        START     = 2'd1,
        WAIT_ACK  = 2'd2,
        WAIT_DONE = 2'd3
    } tx_state_e;

endpackage

// File: rtl/sync_fifo.sv
// Single-clock FIFO with wrapping pointers, registered level/full/empty,
// synchronous flush and a first-word-fall-through head output.
module sync_fifo
    import uart_pkg::*;
#(
    parameter int DATA_W = DEFAULT_DATA_W,
    parameter int DEPTH  = DEFAULT_DEPTH,
    parameter int LVL_W  = $clog2(DEPTH) + 1
) (
    input  logic              clk_50M,
    input  logic              reset_n,
    input  logic              push,
    input  logic              pop,
    input  logic              flush,
    input  logic [DATA_W-1:0] wr_data,
    output logic [DATA_W-1:0] head,
    output logic [LVL_W-1:0]  level,
    output logic              full,
    output logic              empty
);

    localparam int PTR_W = $clog2(DEPTH);

    logic [DATA_W-1:0] mem [DEPTH];

    logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
    logic [LVL_W-1:0] level_q,  level_d;
    logic             full_q,   full_d;
    logic             empty_q,  empty_d;

    // Next pointer/level state; flush wins over both push and pop.
    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        level_d  = level_q;
        if (flush) begin
            wr_ptr_d = '0;
            rd_ptr_d = '0;
            level_d  = '0;
        end else begin
            if (push) wr_ptr_d = wr_ptr_q + PTR_W'(1);
            if (pop)  rd_ptr_d = rd_ptr_q + PTR_W'(1);
            case ({push, pop})
                2'b10:   level_d = level_q + LVL_W'(1);
                2'b01:   level_d = level_q - LVL_W'(1);
                default: level_d = level_q;
            endcase
        end
        full_d  = (level_d == LVL_W'(DEPTH));
        empty_d = (level_d == '0);
    end

    // Pointer and status registers.
    always_ff @(posedge clk_50M or negedge reset_n) begin
        if (!reset_n) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            level_q  <= '0;
            full_q   <= 1'b0;
            empty_q  <= 1'b1;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            level_q  <= level_d;
            full_q   <= full_d;
            empty_q  <= empty_d;
        end
    end

    // Storage array; at full a simultaneous pop frees the slot being written,
    // and the head has already been read combinationally this cycle.
    always_ff @(posedge clk_50M) begin
        if (push && !flush) mem[wr_ptr_q] <= wr_data;
    end

    assign head  = mem[rd_ptr_q];
    assign level = level_q;
    assign full  = full_q;
    assign empty = empty_q;

endmodule

// File: rtl/uart_tx_write_buffer.sv
// Host-side transmit buffer: queues host writes and launches one start pulse
// per word towards the UART transmitter whenever it is idle.
module uart_tx_write_buffer
    import uart_pkg::*;
#(
    parameter int DATA_W = DEFAULT_DATA_W,
    parameter int DEPTH  = DEFAULT_DEPTH,
    parameter int LVL_W  = $clog2(DEPTH) + 1
) (
    input  logic              clk_50M,
    input  logic              reset_n,
    input  logic              write,
    input  logic [DATA_W-1:0] write_data,
    input  logic              flush,
    input  logic              clr_ovf,
    input  logic              tx_busy,
    output logic              start,
    output logic [DATA_W-1:0] tx_data,
    output logic              full,
    output logic              empty,
    output logic [LVL_W-1:0]  level,
    output logic              overflow
);

    tx_state_e         state_q;
    logic              start_q;
    logic [DATA_W-1:0] tx_data_q;
    logic              overflow_q, overflow_d;

    logic              pop;
    logic              push;
    logic              drop;
    logic [DATA_W-1:0] fifo_head;
    logic              fifo_full;
    logic              fifo_empty;

    // Pop/push/drop decode and sticky overflow next state (a drop beats a clear).
    always_comb begin
        pop  = (state_q == IDLE) && !fifo_empty && !tx_busy && !flush;
        push = write && !flush && (!fifo_full || pop);
        drop = write && !flush && fifo_full && !pop;
        overflow_d = overflow_q;
        if (drop)         overflow_d = 1'b1;
        else if (clr_ovf) overflow_d = 1'b0;
    end

    sync_fifo #(
        .DATA_W (DATA_W),
        .DEPTH  (DEPTH),
        .LVL_W  (LVL_W)
    ) u_fifo (
        .clk_50M (clk_50M),
        .reset_n (reset_n),
        .push    (push),
        .pop     (pop),
        .flush   (flush),
        .wr_data (write_data),
        .head    (fifo_head),
        .level   (level),
        .full    (fifo_full),
        .empty   (fifo_empty)
    );

    // Launch FSM with registered start pulse and held transmit word.
    always_ff @(posedge clk_50M or negedge reset_n) begin
        if (!reset_n) begin
            state_q   <= IDLE;
            start_q   <= 1'b0;
            tx_data_q <= '0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (pop) begin
                        tx_data_q <= fifo_head;
                        start_q   <= 1'b1;
                        state_q   <= START;
                    end
                end
                START: begin
                    start_q <= 1'b0;
                    state_q <= tx_busy ? WAIT_DONE : WAIT_ACK;
                end
                WAIT_ACK: begin
                    if (tx_busy) state_q <= WAIT_DONE;
                end
                WAIT_DONE: begin
                    if (!tx_busy) state_q <= IDLE;
                end
                default: begin
                    start_q <= 1'b0;
                    state_q <= IDLE;
                end
            endcase
        end
    end

    // Sticky overflow flag.
    always_ff @(posedge clk_50M or negedge reset_n) begin
        if (!reset_n) overflow_q <= 1'b0;
        else          overflow_q <= overflow_d;
    end

    assign start    = start_q;
    assign tx_data  = tx_data_q;
    assign full     = fifo_full;
    assign empty    = fifo_empty;
    assign overflow = overflow_q;

endmodule

// File: tb/tb_uart_tx_write_buffer.sv
// Bench for uart_tx_write_buffer: directed scenarios plus a randomized run,
// checked against a queue-based reference model of the buffer.
module tb_uart_tx_write_buffer;

    localparam int DEPTH = 16;
    localparam int LVL_W = 5;

    logic             clk_50M = 1'b0;
    logic             reset_n = 1'b0;
    logic             write = 1'b0;
    logic [7:0]       write_data = 8'h00;
    logic             flush = 1'b0;
    logic             clr_ovf = 1'b0;
    logic             tx_busy = 1'b0;
    logic             start;
    logic [7:0]       tx_data;
    logic             full;
    logic             empty;
    logic [LVL_W-1:0] level;
    logic             overflow;

    int n_tests = 0;
    int n_fail  = 0;

    // Reference model: queued words, sticky flag, and the in-flight word.
    // m_phase: 0 = free to launch, 1 = waiting for busy, 2 = waiting for busy to drop.
    logic [7:0] mq[$];
    bit         m_ovf;
    int         m_phase;
    bit         m_start;
    logic [7:0] m_txd;
    int         tx_left;

    uart_tx_write_buffer #(.DATA_W(8), .DEPTH(DEPTH), .LVL_W(LVL_W)) dut (
        .clk_50M    (clk_50M),
        .reset_n    (reset_n),
        .write      (write),
        .write_data (write_data),
        .flush      (flush),
        .clr_ovf    (clr_ovf),
        .tx_busy    (tx_busy),
        .start      (start),
        .tx_data    (tx_data),
        .full       (full),
        .empty      (empty),
        .level      (level),
        .overflow   (overflow)
    );

    always #10 clk_50M = ~clk_50M;

    initial begin
        #2ms;
        $display("FAIL watchdog: simulation time limit reached, tests=%0d", n_tests);
        $fatal(1, "watchdog");
    end

    task automatic model_reset();
        mq.delete();
        m_ovf   = 1'b0;
        m_phase = 0;
        m_start = 1'b0;
        m_txd   = 8'h00;
    endtask

    // Advance one clock edge, apply the buffer rules to the model using the
    // inputs present at that edge, then settle 1 time unit past the edge.
    task automatic step();
        bit do_pop, do_push, drop, was_full;
        @(posedge clk_50M);
        if (!reset_n) begin
            model_reset();
        end else begin
            was_full = (mq.size() == DEPTH);
            do_pop   = (m_phase == 0) && (mq.size() > 0) && !tx_busy && !flush;
            do_push  = write && !flush && (!was_full || do_pop);
            drop     = write && !flush && was_full && !do_pop;
            m_start  = do_pop;
            if (flush) begin
                mq.delete();
            end else begin
                if (do_pop) m_txd = mq.pop_front();
                if (do_push) mq.push_back(write_data);
            end
            if (drop)         m_ovf = 1'b1;
            else if (clr_ovf) m_ovf = 1'b0;
            if (do_pop)                         m_phase = 1;
            else if (m_phase == 1 && tx_busy)   m_phase = 2;
            else if (m_phase == 2 && !tx_busy)  m_phase = 0;
        end
        #1;
    endtask

    // Transmitter stand-in: goes busy for a few cycles after each start.
    task automatic tx_react();
        if (start === 1'b1) tx_left = 3 + int'($urandom_range(0, 3));
        if (tx_left > 0) begin
            tx_busy = 1'b1;
            tx_left--;
        end else begin
            tx_busy = 1'b0;
        end
    endtask

    task automatic test_reset();
        step();
        step();
        n_tests++;
        if ({start, tx_data, full, empty, level, overflow} !== {1'b0, 8'h00, 1'b0, 1'b1, 5'd0, 1'b0}) begin
            n_fail++;
            $display("FAIL reset_values: start=%b tx_data=%h full=%b empty=%b level=%0d ovf=%b, want 0 00 0 1 0 0",
                     start, tx_data, full, empty, level, overflow);
        end
        #3 reset_n = 1'b1;
        step();
        n_tests++;
        if (start !== 1'b0 || level !== 5'd0) begin
            n_fail++;
            $display("FAIL after_reset_idle: start=%b level=%0d, want 0 0", start, level);
        end
    endtask

    task automatic test_single_word();
        int starts;
        write = 1'b1; write_data = 8'hA5;
        step();
        write = 1'b0;
        n_tests++;
        if (level !== 5'd1 || start !== 1'b0 || empty !== 1'b0) begin
            n_fail++;
            $display("FAIL single_level1: level=%0d start=%b empty=%b, want 1 0 0", level, start, empty);
        end
        step();
        n_tests++;
        if (start !== 1'b1 || tx_data !== 8'hA5 || level !== 5'd0) begin
            n_fail++;
            $display("FAIL single_start: start=%b tx_data=%h level=%0d, want 1 a5 0", start, tx_data, level);
        end
        starts = 0;
        tx_busy = 1'b1;
        for (int i = 0; i < 10; i++) begin
            step();
            if (start === 1'b1) starts++;
        end
        tx_busy = 1'b0;
        for (int i = 0; i < 6; i++) begin
            step();
            if (start === 1'b1) starts++;
        end
        n_tests++;
        if (starts != 0 || tx_data !== 8'hA5) begin
            n_fail++;
            $display("FAIL single_no_second_start: extra_starts=%0d tx_data=%h, want 0 a5", starts, tx_data);
        end
    endtask

    task automatic test_burst_overflow();
        int got;
        tx_busy = 1'b1;
        for (int i = 1; i <= 16; i++) begin
            write = 1'b1; write_data = 8'(i);
            step();
        end
        n_tests++;
        if (full !== 1'b1 || level !== 5'd16 || overflow !== 1'b0) begin
            n_fail++;
            $display("FAIL burst_full: full=%b level=%0d ovf=%b, want 1 16 0", full, level, overflow);
        end
        write_data = 8'h11;
        step();
        write = 1'b0;
        n_tests++;
        if (overflow !== 1'b1 || level !== 5'd16) begin
            n_fail++;
            $display("FAIL burst_drop: ovf=%b level=%0d, want 1 16", overflow, level);
        end
        tx_left = 0;
        tx_busy = 1'b0;
        got = 0;
        for (int c = 0; c < 400 && got < 17; c++) begin
            step();
            if (start === 1'b1) begin
                n_tests++;
                if (tx_data !== 8'(got + 1)) begin
                    n_fail++;
                    $display("FAIL burst_order[%0d]: tx_data=%h, want %h", got, tx_data, 8'(got + 1));
                end
                got++;
            end
            tx_react();
        end
        n_tests++;
        if (got != 16 || empty !== 1'b1) begin
            n_fail++;
            $display("FAIL burst_count: starts=%0d empty=%b, want 16 1", got, empty);
        end
    endtask

    task automatic test_push_pop_full();
        logic [7:0] exp_w [17];
        int got;
        tx_busy = 1'b1; clr_ovf = 1'b1;
        step();
        clr_ovf = 1'b0;
        for (int i = 0; i < 16; i++) begin
            exp_w[i] = 8'($urandom_range(0, 255));
            write = 1'b1; write_data = exp_w[i];
            step();
        end
        exp_w[16] = 8'h22;
        write_data = 8'h22; tx_busy = 1'b0;
        step();
        write = 1'b0;
        n_tests++;
        if (start !== 1'b1 || tx_data !== exp_w[0] || level !== 5'd16 || overflow !== 1'b0) begin
            n_fail++;
            $display("FAIL pushpop_full: start=%b tx_data=%h level=%0d ovf=%b, want 1 %h 16 0",
                     start, tx_data, level, overflow, exp_w[0]);
        end
        tx_left = 0;
        tx_react();
        got = 1;
        for (int c = 0; c < 400 && got < 18; c++) begin
            step();
            if (start === 1'b1) begin
                n_tests++;
                if (got > 16 || tx_data !== exp_w[got]) begin
                    n_fail++;
                    $display("FAIL pushpop_order[%0d]: tx_data=%h", got, tx_data);
                end
                got++;
            end
            tx_react();
        end
        n_tests++;
        if (got != 17) begin
            n_fail++;
            $display("FAIL pushpop_count: words=%0d, want 17", got);
        end
    endtask

    task automatic test_flush_midframe();
        logic [7:0] w [5];
        int starts;
        tx_busy = 1'b0;
        for (int i = 0; i < 5; i++) begin
            w[i] = 8'($urandom_range(0, 255));
            write = 1'b1; write_data = w[i];
            step();
            if (i == 1) tx_busy = 1'b1;
        end
        write = 1'b0;
        n_tests++;
        if (level !== 5'd4 || tx_data !== w[0]) begin
            n_fail++;
            $display("FAIL flush_setup: level=%0d tx_data=%h, want 4 %h", level, tx_data, w[0]);
        end
        flush = 1'b1; write = 1'b1; write_data = 8'hEE;
        step();
        flush = 1'b0; write = 1'b0;
        n_tests++;
        if (level !== 5'd0 || empty !== 1'b1 || tx_data !== w[0] || start !== 1'b0) begin
            n_fail++;
            $display("FAIL flush_clear: level=%0d empty=%b tx_data=%h start=%b, want 0 1 %h 0",
                     level, empty, tx_data, start, w[0]);
        end
        starts = 0;
        for (int i = 0; i < 20; i++) begin
            if (i == 3) tx_busy = 1'b0;
            step();
            if (start === 1'b1) starts++;
        end
        n_tests++;
        if (starts != 0 || tx_data !== w[0]) begin
            n_fail++;
            $display("FAIL flush_no_start: starts=%0d tx_data=%h, want 0 %h", starts, tx_data, w[0]);
        end
    endtask

    task automatic test_overflow_clear();
        tx_busy = 1'b1;
        for (int i = 0; i < 17; i++) begin
            write = 1'b1; write_data = 8'h80 | 8'($urandom_range(0, 127));
            step();
        end
        n_tests++;
        if (overflow !== 1'b1) begin
            n_fail++;
            $display("FAIL ovf_set: ovf=%b, want 1", overflow);
        end
        clr_ovf = 1'b1;
        step();
        n_tests++;
        if (overflow !== 1'b1) begin
            n_fail++;
            $display("FAIL ovf_set_wins: ovf=%b, want 1", overflow);
        end
        write = 1'b0;
        step();
        clr_ovf = 1'b0;
        n_tests++;
        if (overflow !== 1'b0 || level !== 5'd16) begin
            n_fail++;
            $display("FAIL ovf_clear: ovf=%b level=%0d, want 0 16", overflow, level);
        end
    endtask

    task automatic test_reset_wait_done();
        int starts;
        tx_busy = 1'b0;
        step();
        n_tests++;
        if (start !== 1'b1 || tx_data[7] !== 1'b1) begin
            n_fail++;
            $display("FAIL rst_setup_start: start=%b tx_data=%h, want 1 with msb set", start, tx_data);
        end
        tx_busy = 1'b1;
        step();
        step();
        write = 1'b1; write_data = 8'h5C;
        step();
        step();
        write = 1'b0;
        n_tests++;
        if (overflow !== m_ovf || overflow !== 1'b1 || level !== 5'd16) begin
            n_fail++;
            $display("FAIL rst_setup_ovf: ovf=%b level=%0d, want 1 16", overflow, level);
        end
        #2 reset_n = 1'b0;
        #1;
        model_reset();
        n_tests++;
        if ({start, tx_data, full, empty, level, overflow} !== {1'b0, 8'h00, 1'b0, 1'b1, 5'd0, 1'b0}) begin
            n_fail++;
            $display("FAIL rst_async: start=%b tx_data=%h full=%b empty=%b level=%0d ovf=%b, want 0 00 0 1 0 0",
                     start, tx_data, full, empty, level, overflow);
        end
        step();
        #3 reset_n = 1'b1;
        tx_busy = 1'b0;
        starts = 0;
        for (int i = 0; i < 20; i++) begin
            step();
            if (start === 1'b1) starts++;
        end
        n_tests++;
        if (starts != 0 || level !== 5'd0 || tx_data !== 8'h00) begin
            n_fail++;
            $display("FAIL rst_no_start: starts=%0d level=%0d tx_data=%h, want 0 0 00", starts, level, tx_data);
        end
    endtask

    task automatic test_random();
        logic [16:0] got_v, exp_v;
        int errs;
        errs = 0;
        for (int c = 0; c < 3000; c++) begin
            write      = ($urandom_range(0, 1) == 1);
            write_data = 8'($urandom_range(0, 255));
            flush      = ($urandom_range(0, 49) == 0);
            clr_ovf    = ($urandom_range(0, 19) == 0);
            if ($urandom_range(0, 5) == 0) tx_busy = ~tx_busy;
            step();
            got_v = {start, tx_data, full, empty, level, overflow};
            exp_v = {m_start, m_txd, (mq.size() == DEPTH), (mq.size() == 0), LVL_W'(mq.size()), m_ovf};
            n_tests++;
            if (got_v !== exp_v) begin
                n_fail++;
                if (errs < 10)
                    $display("FAIL random[%0d]: {start,tx_data,full,empty,level,ovf}=%h, want %h", c, got_v, exp_v);
                errs++;
            end
        end
        write = 1'b0; flush = 1'b0; clr_ovf = 1'b0; tx_busy = 1'b0;
    endtask

    initial begin
        model_reset();
        tx_left = 0;
        test_reset();
        test_single_word();
        test_burst_overflow();
        test_push_pop_full();
        test_flush_midframe();
        test_overflow_clear();
        test_reset_wait_done();
        test_random();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
